// File: rtl/d_stage_if.sv
// ----------------------------------------------------------------------------
// d_stage_if -- decode-stage register-file bus.
//
// Groups the instruction, write-back and read-data signals of d_stage.
//   write  : register-file write enable, active-high
//   rd_i   : write-back data (DATA_W)
//   instr  : 32-bit MIPS-format instruction (opcode/rs/rt/rd/shamt/funct)
//   rs_o   : contents of register instr[25:21] (DATA_W)
//   rt_o   : contents of register instr[20:16] (DATA_W)
// Modports: master drives instr/write/rd_i, slave (d_stage) drives rs_o/rt_o.
// ----------------------------------------------------------------------------
interface d_stage_if #(
  parameter int DATA_W = 32
);
  logic              write;
  logic [DATA_W-1:0] rd_i;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rs_o;
  logic [DATA_W-1:0] rt_o;

  modport master (
    output write,
    output rd_i,
    output instr,
    input  rs_o,
    input  rt_o
  );

  modport slave (
    input  write,
    input  rd_i,
    input  instr,
    output rs_o,
    output rt_o
  );
endinterface

// File: rtl/d_stage.sv
// ----------------------------------------------------------------------------
// d_stage -- MIPS decode-stage register file.
//
// Holds NUM_REGS x DATA_W registers with two combinational read ports
// (rs, rt) and one synchronous write port. The write destination is the rd
// field for R-type instructions and the rt field for every other opcode.
// The opcode never gates a write; bus.write is the only qualifier.
//
// Ports:
//   clk   : single clock, writes on the rising edge
//   reset : asynchronous active-low reset, clears every register
//   bus   : d_stage_if.slave (write, rd_i, instr in; rs_o, rt_o out)
//
// Configuration macro:
//   D_ZERO_REG_EN : when defined, register 0 reads as zero and writes to it
//                   are dropped. Undefined (default): register 0 is ordinary.
// ----------------------------------------------------------------------------
module d_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic       clk,
  input  logic       reset,
  d_stage_if.slave   bus
);

  localparam int         ADDR_W   = 5;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [5:0]        opcode_s;
  logic [ADDR_W-1:0] rs_addr_s;
  logic [ADDR_W-1:0] rt_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] dest_addr_s;
  logic              wr_en_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;

  // True when a 5-bit address maps onto an implemented register.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return ({{(32-ADDR_W){1'b0}}, addr} < NUM_REGS);
  endfunction

  assign opcode_s  = bus.instr[31:26];
  assign rs_addr_s = bus.instr[25:21];
  assign rt_addr_s = bus.instr[20:16];
  assign rd_addr_s = bus.instr[15:11];

  // Destination select and write qualification.
  always_comb begin
    dest_addr_s = rt_addr_s;
    wr_en_s     = 1'b0;
    if (opcode_s == OP_RTYPE) begin
      dest_addr_s = rd_addr_s;
    end else begin
      dest_addr_s = rt_addr_s;
    end
`ifdef D_ZERO_REG_EN
    if (bus.write && addr_in_range(dest_addr_s) && (dest_addr_s != 5'd0)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
`else
    if (bus.write && addr_in_range(dest_addr_s)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
`endif
  end

  // Register-file storage: async clear, one write per rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_q[dest_addr_s] <= bus.rd_i;
    end
  end

  // Read ports: no write bypass, so a same-cycle write shows only after the
  // edge. Reset forces zero explicitly so outputs do not depend on the clear
  // having propagated through the storage.
  always_comb begin
    rs_data_s = '0;
    rt_data_s = '0;
    if (reset && addr_in_range(rs_addr_s)) begin
      rs_data_s = regs_q[rs_addr_s];
    end else begin
      rs_data_s = '0;
    end
    if (reset && addr_in_range(rt_addr_s)) begin
      rt_data_s = regs_q[rt_addr_s];
    end else begin
      rt_data_s = '0;
    end
`ifdef D_ZERO_REG_EN
    if (rs_addr_s == 5'd0) begin
      rs_data_s = '0;
    end else begin
      rs_data_s = rs_data_s;
    end
    if (rt_addr_s == 5'd0) begin
      rt_data_s = '0;
    end else begin
      rt_data_s = rt_data_s;
    end
`endif
  end

  assign bus.rs_o = rs_data_s;
  assign bus.rt_o = rt_data_s;

endmodule

// File: tb/tb_d_stage.sv
// ----------------------------------------------------------------------------
// tb_d_stage -- directed self-checking bench for d_stage (DATA_W = 32).
// Inputs change after the falling edge; outputs are sampled #1 later or #1
// after a rising edge. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_d_stage;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] PAT_A = 32'hAAAA_AAAA;
`ifdef D_ZERO_REG_EN
  localparam logic [31:0] EXP_R0 = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_R0 = 32'hAAAA_AAAA;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  d_stage_if #(.DATA_W(32)) bus ();

  d_stage #(
    .DATA_W   (32),
    .NUM_REGS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time bound so the run always terminates.
  initial begin
    #50000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 5'd0, 6'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic wr, input logic [31:0] data);
    bus.instr = ins;
    bus.write = wr;
    bus.rd_i  = data;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset state.
    reset = 1'b0;
    drive(mk(OP_J, 5'd3, 5'd7, 5'd0), 1'b0, PAT_A);
    #1;
    check("reset_rs", bus.rs_o, 32'h0000_0000);
    check("reset_rt", bus.rt_o, 32'h0000_0000);

    // Write during reset is ignored.
    drive(mk(OP_RTYPE, 5'd3, 5'd3, 5'd3), 1'b1, 32'h1111_1111);
    edge_step();
    check("reset_wr_ignored", bus.rs_o, 32'h0000_0000);

    // Release, then write register 0 via R-type.
    @(negedge clk);
    reset = 1'b1;
    drive(mk(OP_RTYPE, 5'd0, 5'd0, 5'd0), 1'b1, PAT_A);
    #1;
    check("r0_before_edge", bus.rs_o, 32'h0000_0000);
    edge_step();
    check("r0_rs", bus.rs_o, EXP_R0);
    check("r0_rt", bus.rt_o, EXP_R0);

    // R-type destination is rd (3), rs/rt read 5/7.
    @(negedge clk);
    drive(mk(OP_RTYPE, 5'd5, 5'd7, 5'd3), 1'b1, PAT_A);
    edge_step();
    check("rtype_rs", bus.rs_o, 32'h0000_0000);
    check("rtype_rt", bus.rt_o, 32'h0000_0000);

    @(negedge clk);
    drive(mk(OP_RTYPE, 5'd3, 5'd1, 5'd0), 1'b0, 32'h0000_0000);
    #1;
    check("follow_rs3", bus.rs_o, PAT_A);
    check("follow_rt1", bus.rt_o, 32'h0000_0000);

    // LW destination is rt (4); old value visible before the edge.
    @(negedge clk);
    drive(mk(OP_LW, 5'd4, 5'd4, 5'd0), 1'b1, PAT_A);
    #1;
    check("lw_before_edge", bus.rs_o, 32'h0000_0000);
    edge_step();
    check("lw_rs4", bus.rs_o, PAT_A);
    check("lw_same_reg_rt", bus.rt_o, PAT_A);

    @(negedge clk);
    drive(mk(OP_SW, 5'd9, 5'd4, 5'd0), 1'b0, 32'h0000_0000);
    #1;
    check("sw_rs9", bus.rs_o, 32'h0000_0000);
    check("sw_rt4", bus.rt_o, PAT_A);

    // write = 0 across two edges leaves contents unchanged.
    @(negedge clk);
    drive(mk(OP_BEQ, 5'd3, 5'd4, 5'd0), 1'b0, 32'h5555_5555);
    edge_step();
    edge_step();
    check("hold_rs3", bus.rs_o, PAT_A);
    check("hold_rt4", bus.rt_o, PAT_A);

    // Opcode does not gate writes: BEQ with write=1 writes rt (9), not rd (2).
    @(negedge clk);
    drive(mk(OP_BEQ, 5'd9, 5'd9, 5'd2), 1'b1, 32'h1234_5678);
    edge_step();
    check("beq_wr_rs9", bus.rs_o, 32'h1234_5678);
    @(negedge clk);
    drive(mk(OP_RTYPE, 5'd2, 5'd0, 5'd0), 1'b0, 32'h0000_0000);
    #1;
    check("beq_rd2_untouched", bus.rs_o, 32'h0000_0000);
    check("r0_still", bus.rt_o, EXP_R0);

    // Consecutive writes to register 10: last one wins.
    @(negedge clk);
    drive(mk(OP_J, 5'd0, 5'd10, 5'd0), 1'b1, 32'h0000_0001);
    edge_step();
    @(negedge clk);
    bus.rd_i = 32'h0000_0002;
    edge_step();
    @(negedge clk);
    drive(mk(OP_RTYPE, 5'd10, 5'd3, 5'd0), 1'b0, 32'h0000_0000);
    #1;
    check("consec_r10", bus.rs_o, 32'h0000_0002);
    check("pre_reset_r3", bus.rt_o, PAT_A);

    // Reset pulsed low between edges: outputs drop immediately, contents lost.
    #1;
    reset = 1'b0;
    #1;
    check("midreset_rs", bus.rs_o, 32'h0000_0000);
    check("midreset_rt", bus.rt_o, 32'h0000_0000);
    #1;
    reset = 1'b1;
    #1;
    check("postreset_r10", bus.rs_o, 32'h0000_0000);
    check("postreset_r3", bus.rt_o, 32'h0000_0000);

    // First write after deassertion lands on the next rising edge.
    @(negedge clk);
    drive(mk(OP_RTYPE, 5'd11, 5'd0, 5'd11), 1'b1, 32'hCAFE_F00D);
    #1;
    check("first_wr_before", bus.rs_o, 32'h0000_0000);
    check("postreset_r0", bus.rt_o, 32'h0000_0000);
    edge_step();
    check("first_wr_after", bus.rs_o, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
